// File: rtl/bs_pack_out.sv
// MSB-first variable-length code packer with ready/valid on both sides and flush-to-byte.
// Define BS_PACK_OUT_BYTE_REV_EN to byte-reverse each output word (first stream byte in dat_o[7:0]).
module bs_pack_out #(
  parameter int DATA_WD = 32,
  parameter int NUMB_WD = 5,
  parameter int BYTE_WD = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               val_i,
  input  logic               flush_i,
  output logic               rdy_o,
  input  logic [DATA_WD-1:0] dat_i,
  input  logic [NUMB_WD-1:0] numb_i,
  output logic               val_o,
  input  logic               rdy_i,
  output logic [DATA_WD-1:0] dat_o,
  output logic [BYTE_WD-1:0] byte_o,
  output logic               last_o
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [BYTE_WD-1:0] FULL_BYTES = BYTE_WD'(DATA_WD / 8);
  localparam logic [NUMB_WD:0]   WD_SUM     = (NUMB_WD + 1)'(DATA_WD);

  state_t               state_q;
  logic [2*DATA_WD-1:0] buf_q;
  logic [NUMB_WD-1:0]   ptr_q;
  logic                 pend_q;
  logic                 val_q;
  logic [DATA_WD-1:0]   dat_q;
  logic [BYTE_WD-1:0]   byte_q;
  logic                 last_q;

  logic                 slot_free_s;
  logic                 accept_s;
  logic [DATA_WD-1:0]   mask_s;
  logic [NUMB_WD:0]     len_s;
  logic [2*DATA_WD-1:0] buf_d;
  logic [2*DATA_WD-1:0] word_wide_s;
  logic [NUMB_WD:0]     sum_s;
  logic [NUMB_WD:0]     ptr_wide_s;
  logic [NUMB_WD-1:0]   ptr_d;
  logic                 full_s;
  logic [DATA_WD-1:0]   word_full_s;

  // Remainder bits sit at the bottom of the buffer; move them to the top of a word.
  function automatic logic [DATA_WD-1:0] align_rem(input logic [DATA_WD-1:0] lo,
                                                   input logic [NUMB_WD-1:0] p);
    logic [NUMB_WD:0] sh;
    sh = WD_SUM - {1'b0, p};
    return lo << sh;
  endfunction

  function automatic logic [BYTE_WD-1:0] ceil_bytes(input logic [NUMB_WD-1:0] p);
    logic [NUMB_WD:0] t;
    t = {1'b0, p} + (NUMB_WD + 1)'(7);
    return t[NUMB_WD:3];
  endfunction

  function automatic logic [DATA_WD-1:0] fmt_word(input logic [DATA_WD-1:0] w);
`ifdef BS_PACK_OUT_BYTE_REV_EN
    logic [DATA_WD-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_WD / 8; i++) begin
      r[8*i +: 8] = w[DATA_WD-8-8*i +: 8];
    end
    return r;
`else
    return w;
`endif
  endfunction

  assign slot_free_s = !val_q | rdy_i;
  assign rdy_o       = (state_q == RUN) & slot_free_s & !rst;
  assign accept_s    = (val_i | flush_i) & rdy_o;

  assign val_o  = val_q;
  assign dat_o  = dat_q;
  assign byte_o = byte_q;
  assign last_o = last_q;

  // Append the masked code and work out whether a full word falls out of the buffer.
  always_comb begin
    mask_s = {DATA_WD{1'b1}} >> (NUMB_WD'(DATA_WD - 1) - numb_i);
    len_s  = {1'b0, numb_i} + (NUMB_WD + 1)'(1);
    if (val_i) begin
      buf_d = (buf_q << len_s) | {{DATA_WD{1'b0}}, dat_i & mask_s};
      sum_s = {1'b0, ptr_q} + len_s;
    end else begin
      buf_d = buf_q;
      sum_s = {1'b0, ptr_q};
    end
    full_s = (sum_s >= WD_SUM);
    if (full_s) begin
      ptr_wide_s = sum_s - WD_SUM;
    end else begin
      ptr_wide_s = sum_s;
    end
    ptr_d       = ptr_wide_s[NUMB_WD-1:0];
    word_wide_s = buf_d >> (sum_s - WD_SUM);
    word_full_s = word_wide_s[DATA_WD-1:0];
  end

  // Packing state, FSM and the registered output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      buf_q   <= '0;
      ptr_q   <= '0;
      pend_q  <= 1'b0;
      val_q   <= 1'b0;
      dat_q   <= '0;
      byte_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      if (val_q && rdy_i) begin
        val_q <= 1'b0;
      end
      case (state_q)
        RUN: begin
          if (accept_s) begin
            buf_q <= buf_d;
            ptr_q <= ptr_d;
            if (full_s) begin
              val_q  <= 1'b1;
              dat_q  <= fmt_word(word_full_s);
              byte_q <= FULL_BYTES;
              last_q <= flush_i && (ptr_d == '0);
              if (flush_i && (ptr_d != '0)) begin
                state_q <= FLUSH;
                pend_q  <= 1'b1;
              end
            end else if (flush_i) begin
              // Slot is known free here, so the tail goes out right away; FLUSH is just the bubble.
              val_q   <= 1'b1;
              dat_q   <= fmt_word(align_rem(buf_d[DATA_WD-1:0], ptr_d));
              byte_q  <= ceil_bytes(ptr_d);
              last_q  <= 1'b1;
              buf_q   <= '0;
              ptr_q   <= '0;
              state_q <= FLUSH;
              pend_q  <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (!pend_q) begin
            state_q <= RUN;
          end else if (slot_free_s) begin
            val_q   <= 1'b1;
            dat_q   <= fmt_word(align_rem(buf_q[DATA_WD-1:0], ptr_q));
            byte_q  <= ceil_bytes(ptr_q);
            last_q  <= 1'b1;
            buf_q   <= '0;
            ptr_q   <= '0;
            pend_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= RUN;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bs_pack_out.sv
// Scoreboard bench for bs_pack_out: directed beats push expected words, a monitor pops on each transfer.
module tb_bs_pack_out;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        val_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        rdy_o;
  logic [31:0] dat_i = 32'h0;
  logic [4:0]  numb_i = 5'd0;
  logic        val_o;
  logic        rdy_i = 1'b1;
  logic [31:0] dat_o;
  logic [2:0]  byte_o;
  logic        last_o;

  typedef struct packed {
    logic [31:0] dat;
    logic [2:0]  nb;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  bs_pack_out #(.DATA_WD(32), .NUMB_WD(5), .BYTE_WD(3)) dut (
    .clk(clk), .rst(rst), .val_i(val_i), .flush_i(flush_i), .rdy_o(rdy_o),
    .dat_i(dat_i), .numb_i(numb_i), .val_o(val_o), .rdy_i(rdy_i),
    .dat_o(dat_o), .byte_o(byte_o), .last_o(last_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_fmt(input logic [31:0] w);
`ifdef BS_PACK_OUT_BYTE_REV_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [31:0] w, input logic [2:0] nb, input logic last);
    exp_t e;
    e.dat  = exp_fmt(w);
    e.nb   = nb;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Issue one beat at posedge+1 and hold it until accepted; returns at posedge+1 after acceptance.
  task automatic send(input logic v, input logic f, input logic [4:0] n, input logic [31:0] d);
    int wait_cyc;
    val_i   = v;
    flush_i = f;
    numb_i  = n;
    dat_i   = d;
    wait_cyc = 0;
    @(negedge clk);
    while (!rdy_o && wait_cyc < 50) begin
      wait_cyc++;
      @(negedge clk);
    end
    if (!rdy_o) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: rdy_o stuck at 0 for %0d cycles", wait_cyc);
    end
    @(posedge clk);
    #1;
    val_i   = 1'b0;
    flush_i = 1'b0;
  endtask

  // Monitor: a word transfers on the next posedge when val_o & rdy_i at the negedge.
  always @(negedge clk) begin
    if (!rst && val_o && rdy_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got 0x%08h byte=%0d last=%0d, none expected", dat_o, byte_o, last_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word_dat", dat_o, e.dat);
        check("word_byte", {29'd0, byte_o}, {29'd0, e.nb});
        check("word_last", {31'd0, last_o}, {31'd0, e.last});
      end
    end
  end

  initial begin
    int guard;
    // Reset state
    @(negedge clk);
    check("rst_val_o", {31'd0, val_o}, 32'd0);
    check("rst_rdy_o", {31'd0, rdy_o}, 32'd0);
    check("rst_dat_o", dat_o, 32'h0);
    check("rst_byte_o", {29'd0, byte_o}, 32'd0);
    check("rst_last_o", {31'd0, last_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Byte packing, upper dat_i bits must be masked
    expect_word(32'hA1B2C3D4, 3'd4, 1'b0);
    send(1'b1, 1'b0, 5'd7, 32'hFFFFFFA1);
    send(1'b1, 1'b0, 5'd7, 32'h000000B2);
    send(1'b1, 1'b0, 5'd7, 32'h000000C3);
    check("bytepack_val_before", {31'd0, val_o}, 32'd0);
    send(1'b1, 1'b0, 5'd7, 32'h000000D4);
    check("bytepack_latency", {31'd0, val_o}, 32'd1);

    // Boundary split and exact flush
    expect_word(32'hABCDE123, 3'd4, 1'b0);
    expect_word(32'h456789AB, 3'd4, 1'b1);
    send(1'b1, 1'b0, 5'd19, 32'h000ABCDE);
    send(1'b1, 1'b0, 5'd19, 32'h00012345);
    send(1'b1, 1'b1, 5'd23, 32'h006789AB);
    @(negedge clk);
    check("exactflush_rdy", {31'd0, rdy_o}, 32'd1);
    @(posedge clk);
    #1;

    // Partial flush with one bubble
    expect_word(32'h12345678, 3'd4, 1'b0);
    expect_word(32'hF0000000, 3'd1, 1'b1);
    send(1'b1, 1'b0, 5'd31, 32'h12345678);
    send(1'b1, 1'b1, 5'd3, 32'h0000000F);
    @(negedge clk);
    check("partflush_bubble", {31'd0, rdy_o}, 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: word held stable, input stalled
    rdy_i = 1'b0;
    expect_word(32'h11223344, 3'd4, 1'b0);
    send(1'b1, 1'b0, 5'd7, 32'h00000011);
    send(1'b1, 1'b0, 5'd7, 32'h00000022);
    send(1'b1, 1'b0, 5'd7, 32'h00000033);
    send(1'b1, 1'b0, 5'd7, 32'h00000044);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rdy_o", {31'd0, rdy_o}, 32'd0);
      check("bp_val_o", {31'd0, val_o}, 32'd1);
      check("bp_dat_o", dat_o, exp_fmt(32'h11223344));
    end
    @(posedge clk);
    #1 rdy_i = 1'b1;
    expect_word(32'hBEEF5566, 3'd4, 1'b0);
    send(1'b1, 1'b0, 5'd15, 32'h0000BEEF);
    send(1'b1, 1'b0, 5'd15, 32'h00005566);

    // Empty flush, then flush of a 12-bit tail
    expect_word(32'h00000000, 3'd0, 1'b1);
    send(1'b0, 1'b1, 5'd0, 32'h0);
    expect_word(32'hABC00000, 3'd2, 1'b1);
    send(1'b1, 1'b0, 5'd11, 32'h00000ABC);
    send(1'b0, 1'b1, 5'd0, 32'h0);

    // Reset mid-stream discards the partial bits
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      guard++;
      @(posedge clk);
    end
    #1;
    send(1'b1, 1'b0, 5'd19, 32'h00012345);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_val_o", {31'd0, val_o}, 32'd0);
    check("midrst_rdy_o", {31'd0, rdy_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    expect_word(32'hCAFEF00D, 3'd4, 1'b0);
    send(1'b1, 1'b0, 5'd31, 32'hCAFEF00D);

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      guard++;
      @(posedge clk);
    end
    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bs_pack_out.md
# bs_pack_out

Parametrised bit-stream packer for the zlib/deflate output path. It accepts variable-length codes of 1..DATA_WD bits per beat and packs them MSB-first into DATA_WD-bit words. Compared with the first-generation packer it adds ready/valid backpressure on both sides, an explicit flush that zero-pads the tail to a byte boundary, a valid-byte count and last flag on the final word, and optional per-word byte reversal. It sits between the Huffman/LZ77 code emitters and the stream/AXI writer.

## Interface
- DATA_WD, 32: input code width and output word width; multiple of 8, power of two, 16..64.
- NUMB_WD, 5: log2(DATA_WD); width of numb_i and of the internal bit pointer.
- BYTE_WD, 3: log2(DATA_WD/8)+1; width of byte_o.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- val_i  in  1  data code valid.
- flush_i  in  1  flush request; may be asserted with or without val_i.
- rdy_o  out  1  input ready; a beat is accepted when (val_i|flush_i)&rdy_o.
- dat_i  in  DATA_WD  code bits; only the low numb_i+1 bits are used, the upper bits are masked internally.
- numb_i  in  NUMB_WD  code length minus 1 (0 = 1 bit, DATA_WD-1 = DATA_WD bits).
- val_o  out  1  output word valid.
- rdy_i  in  1  downstream ready.
- dat_o  out  DATA_WD  packed word; the first bit in the stream is at bit DATA_WD-1.
- byte_o  out  BYTE_WD  number of valid bytes in dat_o (DATA_WD/8 for full words, 0..DATA_WD/8 on the last word).
- last_o  out  1  final word of a flushed stream.

## Operation
- State: 2·DATA_WD-bit buffer, NUMB_WD-bit pointer ptr (remainder bits, 0..DATA_WD-1), one output register, and an FSM with states RUN and FLUSH.
- rdy_o = (state==RUN) & (!val_o | rdy_i). rdy_o is 0 while rst is high.
- Data beat (val_i=1): buffer ← (buffer << (numb_i+1)) | masked dat_i; sum = ptr + numb_i + 1 (NUMB_WD+1 bits).
  - If sum ≥ DATA_WD, the oldest DATA_WD bits load into the output register with byte_o=DATA_WD/8, and ptr ← sum-DATA_WD.
  - Otherwise ptr ← sum.
- Flush beat (flush_i=1): any same-cycle data is appended first. Then:
  - If a full word completes and the new ptr is 0, that word carries last_o=1, the FSM stays in RUN, and no extra word is emitted.
  - If a full word completes and the new ptr is not 0, the word carries last_o=0 and the FSM goes to FLUSH.
  - If no word completes, the FSM goes to FLUSH.
- FLUSH: when the output slot is free (!val_o | rdy_i), emit the remainder left-aligned and zero-padded.
  - byte_o = ceil(ptr/8), last_o=1.
  - ptr ← 0, buffer ← 0, FSM → RUN.
  - A flush with ptr=0 and no data emits dat_o=0, byte_o=0, last_o=1.
- Output register holds dat_o/byte_o/last_o stable while val_o & !rdy_i. val_o clears on val_o & rdy_i unless it is reloaded in the same cycle.
- Reset, including mid-stream: val_o=0, dat_o=0, byte_o=0, last_o=0, ptr=0, buffer=0, FSM=RUN. Partial bits are discarded.

## Timing
- The output is registered. A beat accepted in cycle t that completes a word gives val_o=1 in t+1.
- Flush remainder word:
  - appears in t+1 if the flush beat produced no full word;
  - otherwise appears in the cycle after the full word is taken (t+2 with rdy_i=1).
- With rdy_i held at 1, one beat is accepted per cycle, except that a flush requiring a FLUSH state costs one bubble.
- No combinational path from dat_i/numb_i to any output. The rdy_i → rdy_o path is combinational.

## Configuration
- BS_PACK_OUT_BYTE_REV_EN defined:
  - dat_o is byte-reversed on load; the first stream byte sits in dat_o[7:0].
  - On a last word, the valid bytes are the low byte_o bytes and the padding bytes are the upper ones.
- Not defined: the first stream byte sits in dat_o[DATA_WD-1:DATA_WD-8] and padding occupies the low bytes.
- Bit order within each byte is identical in both modes.

## Test plan
All scenarios use DATA_WD=32, macro undefined unless noted.
- Byte packing: rdy_i=1; 4 beats numb_i=7, dat 0xA1,0xB2,0xC3,0xD4 → one word 0xA1B2C3D4, byte_o=4, last_o=0, one cycle after the 4th beat.
- Boundary split and exact flush: numb_i=19 0xABCDE, then numb_i=19 0x12345 → word 0xABCDE123. Then flush_i with numb_i=23 0x6789AB → word 0x456789AB, byte_o=4, last_o=1; no further word.
- Partial flush: numb_i=31 0x12345678, then numb_i=3 0xF with flush_i → 0x12345678 (last_o=0), then 0xF0000000, byte_o=1, last_o=1, one bubble on rdy_o. With BS_PACK_OUT_BYTE_REV_EN the words are 0x78563412 and 0x000000F0.
- Backpressure: rdy_i=0 with a word pending → rdy_o=0, dat_o/val_o stable for 5 cycles. On release, all following words arrive intact and in order.
- Empty flush: flush_i alone with ptr=0 → dat_o=0, byte_o=0, last_o=1.
- Reset mid-stream: 20 bits accepted, pulse rst → val_o=0, rdy_o=0 during rst. After release, numb_i=31 0xCAFEF00D → word 0xCAFEF00D.
